// File: rtl/segment_pkg.sv
// Shared constants and types for the seven-segment display bus.
package segment_pkg;

  localparam int unsigned SEG_W   = 9;
  localparam int unsigned GLYPH_W = 7;
  localparam int unsigned DIGIT_W = 4;
  localparam int unsigned SEG_DP  = 7;
  localparam int unsigned SEG_RST = 8;

  // Bus value while the source display driver is held in reset.
  localparam logic [SEG_W-1:0] SEG_RESET_VAL = 9'h100;

  // Segment patterns a..g for hex digits 0..F, indexed by digit value.
  localparam logic [15:0][GLYPH_W-1:0] GLYPH_TABLE = {
    7'h71, 7'h79, 7'h5e, 7'h39, 7'h7c, 7'h77, 7'h6f, 7'h7f,
    7'h07, 7'h7d, 7'h6d, 7'h66, 7'h4f, 7'h5b, 7'h06, 7'h3f
  };

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    LOCKED
  } seg_rb_state_t;

endpackage

// File: rtl/seg_glyph_decode.sv
// Maps a 7-bit segment pattern to a decimal digit; anything but 0..9 is illegal.
module seg_glyph_decode
  import segment_pkg::*;
(
  input  logic [GLYPH_W-1:0] pattern,
  output logic [DIGIT_W-1:0] digit_c,
  output logic               illegal_c
);

  // Search the decimal glyphs only; hex letters are not a valid display.
  always_comb begin
    digit_c   = '0;
    illegal_c = 1'b1;
    for (int unsigned i = 0; i < 10; i++) begin
      if (pattern == GLYPH_TABLE[i]) begin
        digit_c   = DIGIT_W'(i);
        illegal_c = 1'b0;
      end
    end
  end

endmodule

// File: rtl/segment_readback.sv
// Recovers the displayed 0..255 count from the two-digit seven-segment buses.
module segment_readback
  import segment_pkg::*;
#(
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [SEG_W-1:0] segment_led_1_i,
  input  logic [SEG_W-1:0] segment_led_2_i,
  output logic [7:0]       count_o,
  output logic             valid_o,
  output logic             locked_o,
  output logic             err_o
);

  localparam int unsigned BUS_W = 2 * SEG_W;
  localparam int unsigned CNT_W = 8;
  localparam int unsigned VAL_W = 10;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);
  localparam logic [BUS_W-1:0] BUS_RESET = {SEG_RESET_VAL, SEG_RESET_VAL};

  logic [BUS_W-1:0] sync_out;

  if (SYNC_STAGES == 0) begin : g_nosync
    assign sync_out = {segment_led_1_i, segment_led_2_i};
  end else begin : g_sync
    logic [BUS_W-1:0] sync_q [SYNC_STAGES];

    // Synchroniser chain, reset to the source-in-reset pattern.
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        for (int unsigned i = 0; i < SYNC_STAGES; i++) sync_q[i] <= BUS_RESET;
      end else begin
        sync_q[0] <= {segment_led_1_i, segment_led_2_i};
        for (int unsigned i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      end
    end

    assign sync_out = sync_q[SYNC_STAGES-1];
  end

  logic [BUS_W-1:0] snap_q;
  logic [CNT_W-1:0] cnt_q;
  logic             diff;
  logic             src_rst;

  assign diff    = (sync_out != snap_q);
  assign src_rst = sync_out[SEG_W + SEG_RST] | sync_out[SEG_RST];

  // Snapshot and stability counter: restart on any change, saturate when steady.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      snap_q <= BUS_RESET;
      cnt_q  <= '0;
    end else if (diff) begin
      snap_q <= sync_out;
      cnt_q  <= CNT_W'(1);
    end else if (cnt_q != CNT_MAX) begin
      cnt_q  <= cnt_q + CNT_W'(1);
    end
  end

  logic [SEG_W-1:0]   seg1;
  logic [SEG_W-1:0]   seg2;
  logic [DIGIT_W-1:0] tens;
  logic [DIGIT_W-1:0] ones;
  logic               tens_ill;
  logic               ones_ill;

  assign seg1 = snap_q[BUS_W-1:SEG_W];
  assign seg2 = snap_q[SEG_W-1:0];

  seg_glyph_decode u_dec_tens (
    .pattern   (seg1[GLYPH_W-1:0]),
    .digit_c   (tens),
    .illegal_c (tens_ill)
  );

  seg_glyph_decode u_dec_ones (
    .pattern   (seg2[GLYPH_W-1:0]),
    .digit_c   (ones),
    .illegal_c (ones_ill)
  );

  logic [1:0]       hundreds;
  logic             dp_ill;
  logic [VAL_W-1:0] value10;
  logic [7:0]       value8;
  logic             snap_legal;

  // Hundreds digit from the two dp flags; "200 but not 100" cannot be displayed.
  always_comb begin
    hundreds = 2'd0;
    dp_ill   = 1'b0;
    case ({seg1[SEG_DP], seg2[SEG_DP]})
      2'b00:   hundreds = 2'd0;
      2'b01:   hundreds = 2'd1;
      2'b11:   hundreds = 2'd2;
      default: dp_ill   = 1'b1;
    endcase
  end

  assign value10 = VAL_W'(hundreds) * VAL_W'(100) + VAL_W'(tens) * VAL_W'(10) + VAL_W'(ones);
  assign value8  = value10[7:0];
  assign snap_legal = !tens_ill && !ones_ill && !dp_ill && (value10 <= VAL_W'(255))
                      && !seg1[SEG_RST] && !seg2[SEG_RST];

  seg_rb_state_t state_q, state_d;
  logic [7:0] count_q, count_d;
  logic       locked_q, locked_d;
  logic       valid_q, valid_d;
  logic       err_q, err_d;
  logic       err_issued_q, err_issued_d;
  logic       first_q, first_d;

  // State and output registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      count_q      <= '0;
      locked_q     <= 1'b0;
      valid_q      <= 1'b0;
      err_q        <= 1'b0;
      err_issued_q <= 1'b0;
      first_q      <= 1'b1;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      locked_q     <= locked_d;
      valid_q      <= valid_d;
      err_q        <= err_d;
      err_issued_q <= err_issued_d;
      first_q      <= first_d;
    end
  end

  // Next state and outputs; a source in reset overrides everything.
  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    locked_d     = locked_q;
    valid_d      = 1'b0;
    err_d        = 1'b0;
    first_d      = first_q;
    err_issued_d = diff ? 1'b0 : err_issued_q;
    if (src_rst) begin
      state_d  = IDLE;
      count_d  = '0;
      locked_d = 1'b0;
      first_d  = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = SETTLE;
        end
        SETTLE: begin
          // Only act on a snapshot that is not being replaced at this edge.
          if (!diff && (cnt_q == CNT_MAX)) begin
            if (snap_legal) begin
              state_d  = LOCKED;
              count_d  = value8;
              locked_d = 1'b1;
              valid_d  = (value8 != count_q) || first_q;
              first_d  = 1'b0;
            end else if (!err_issued_q) begin
              err_d        = 1'b1;
              err_issued_d = 1'b1;
            end
          end
        end
        LOCKED: begin
          if (diff) begin
            state_d  = SETTLE;
            locked_d = 1'b0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign count_o  = count_q;
  assign valid_o  = valid_q;
  assign locked_o = locked_q;
  assign err_o    = err_q;

endmodule

// File: tb/tb_segment_readback.sv
// Self-checking bench for segment_readback with a decoding reference model.
module tb_segment_readback;

  localparam int S = 2;
  localparam int N = 4;
  localparam int L = S + N + 1;

  logic       clk = 1'b0;
  logic       rst;
  logic [8:0] s1, s2;
  logic [7:0] count;
  logic       valid, locked, err;

  logic       frst;
  logic [8:0] f1, f2;
  logic [7:0] fcount;
  logic       fvalid, flocked, ferr;

  int tests = 0;
  int fails = 0;

  int glyph_ref [10] = '{'h3f, 'h06, 'h5b, 'h4f, 'h66, 'h6d, 'h7d, 'h07, 'h7f, 'h6f};

  int         m_count = 0;
  bit         m_first = 1'b1;
  logic [8:0] p1 = 9'h100;
  logic [8:0] p2 = 9'h100;

  always #5 clk = ~clk;

  segment_readback #(.SYNC_STAGES(S), .STABLE_CYCLES(N)) dut (
    .clk_i(clk), .rst_i(rst), .segment_led_1_i(s1), .segment_led_2_i(s2),
    .count_o(count), .valid_o(valid), .locked_o(locked), .err_o(err)
  );

  segment_readback #(.SYNC_STAGES(0), .STABLE_CYCLES(1)) dut_fast (
    .clk_i(clk), .rst_i(frst), .segment_led_1_i(f1), .segment_led_2_i(f2),
    .count_o(fcount), .valid_o(fvalid), .locked_o(flocked), .err_o(ferr)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int digit_of(input logic [6:0] p);
    for (int i = 0; i < 10; i++) if (int'(p) == glyph_ref[i]) return i;
    return -1;
  endfunction

  // Expected displayed value, or -1 if the pair of buses is not a legal display.
  function automatic int ref_value(input logic [8:0] a, input logic [8:0] b);
    int t, o, h, v;
    t = digit_of(a[6:0]);
    o = digit_of(b[6:0]);
    if (t < 0 || o < 0 || a[8] || b[8]) return -1;
    if (a[7] && !b[7]) return -1;
    h = a[7] ? 2 : (b[7] ? 1 : 0);
    v = h * 100 + t * 10 + o;
    return (v > 255) ? -1 : v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic gen_bus(input bit allow_illegal, output logic [8:0] a, output logic [8:0] b);
    int h, t, o;
    if (allow_illegal && $urandom_range(0, 3) == 0) begin
      a = {1'b0, 8'($urandom)};
      b = {1'b0, 8'($urandom)};
    end else begin
      h = int'($urandom_range(0, 2));
      t = int'($urandom_range(0, 9));
      o = int'($urandom_range(0, 9));
      a = {1'b0, (h == 2), 7'(glyph_ref[t])};
      b = {1'b0, (h >= 1), 7'(glyph_ref[o])};
    end
  endtask

  // Apply a new steady value and check the strobes, timing and final outputs.
  task automatic hold(input logic [8:0] a, input logic [8:0] b, input string tag);
    int v, vcnt, ecnt, vcyc, ecyc;
    bit exp_valid;
    v = ref_value(a, b);
    vcnt = 0; ecnt = 0; vcyc = -1; ecyc = -1;
    s1 = a;
    s2 = b;
    for (int c = 1; c <= L + 4; c++) begin
      step();
      if (valid) begin vcnt++; vcyc = c; end
      if (err) begin ecnt++; ecyc = c; end
      check($sformatf("%s_excl_c%0d", tag, c), 32'(valid & err), 0);
      if (c == L - 1) check($sformatf("%s_locked_settle", tag), 32'(locked), 0);
    end
    if (v >= 0) begin
      exp_valid = (v != m_count) || m_first;
      check($sformatf("%s_valid_n", tag), vcnt, exp_valid ? 1 : 0);
      if (exp_valid) check($sformatf("%s_valid_cyc", tag), vcyc, L);
      check($sformatf("%s_err_n", tag), ecnt, 0);
      check($sformatf("%s_count", tag), 32'(count), v);
      check($sformatf("%s_locked", tag), 32'(locked), 1);
      m_count = v;
      m_first = 1'b0;
    end else begin
      check($sformatf("%s_err_n", tag), ecnt, 1);
      check($sformatf("%s_err_cyc", tag), ecyc, L);
      check($sformatf("%s_valid_n", tag), vcnt, 0);
      check($sformatf("%s_count", tag), 32'(count), m_count);
      check($sformatf("%s_locked", tag), 32'(locked), 0);
    end
    p1 = a;
    p2 = b;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [8:0] a, b;
    int vcnt, ecnt, saw_unlock, fm, fv, fvcyc;
    bit ffirst;

    rst = 1'b1; s1 = 9'h100; s2 = 9'h100;
    frst = 1'b1; f1 = 9'h100; f2 = 9'h100;
    repeat (3) step();
    check("rst_count", 32'(count), 0);
    check("rst_valid", 32'(valid), 0);
    check("rst_locked", 32'(locked), 0);
    check("rst_err", 32'(err), 0);
    rst = 1'b0;

    hold(9'h05b, 9'h0cf, "v123");

    // Two short glitches on the ones digit, then back to 123.
    vcnt = 0; ecnt = 0; saw_unlock = 0;
    for (int c = 0; c < 16; c++) begin
      s2 = (c == 0 || c == 2) ? 9'h0c6 : 9'h0cf;
      step();
      if (valid) vcnt++;
      if (err) ecnt++;
      if (!locked) saw_unlock = 1;
    end
    check("glitch_unlock", saw_unlock, 1);
    check("glitch_valid_n", vcnt, 0);
    check("glitch_err_n", ecnt, 0);
    check("glitch_count", 32'(count), 123);
    check("glitch_locked", 32'(locked), 1);

    hold(9'h0ed, 9'h0ed, "v255");
    hold(9'h0ed, 9'h0fd, "v256");
    hold(9'h05b, 9'h0cf, "v123b");
    hold(9'h05b, 9'h077, "glyph_a");
    hold(9'h0bf, 9'h03f, "dp10");
    hold(9'h05b, 9'h0cf, "v123c");

    // Source reset on the tens bus while locked.
    s1 = p1 | 9'h100;
    vcnt = 0; ecnt = 0;
    for (int c = 1; c <= 3; c++) begin
      step();
      if (valid) vcnt++;
      if (err) ecnt++;
      if (c == 2) check("srst_locked_c2", 32'(locked), 1);
    end
    check("srst_count", 32'(count), 0);
    check("srst_locked", 32'(locked), 0);
    check("srst_strobes", vcnt + ecnt, 0);
    m_count = 0;
    m_first = 1'b1;
    p1 = s1;
    hold(9'h03f, 9'h03f, "v000");

    for (int i = 0; i < 16; i++) begin
      do gen_bus(1'b1, a, b); while ({a, b} === {p1, p2});
      hold(a, b, $sformatf("rnd%0d", i));
    end

    // Local reset part-way through settling.
    s1 = 9'h006; s2 = 9'h006;
    repeat (4) step();
    rst = 1'b1;
    step();
    check("lrst_count", 32'(count), 0);
    check("lrst_valid", 32'(valid), 0);
    check("lrst_locked", 32'(locked), 0);
    check("lrst_err", 32'(err), 0);
    rst = 1'b0;
    m_count = 0; m_first = 1'b1; p1 = 9'h100; p2 = 9'h100;
    hold(9'h006, 9'h006, "v011");

    // Minimum-latency configuration.
    step();
    frst = 1'b0;
    fm = 0; ffirst = 1'b1;
    for (int k = 0; k < 6; k++) begin
      do begin
        gen_bus(1'b0, a, b);
        fv = ref_value(a, b);
      end while (fv < 0 || (!ffirst && fv == fm));
      f1 = a; f2 = b;
      fvcyc = -1; vcnt = 0;
      for (int c = 1; c <= 4; c++) begin
        step();
        if (fvalid) begin vcnt++; fvcyc = c; end
      end
      check($sformatf("fast%0d_valid_n", k), vcnt, 1);
      check($sformatf("fast%0d_valid_cyc", k), fvcyc, 2);
      check($sformatf("fast%0d_count", k), 32'(fcount), fv);
      check($sformatf("fast%0d_locked", k), 32'(flocked), 1);
      check($sformatf("fast%0d_err", k), 32'(ferr), 0);
      fm = fv; ffirst = 1'b0;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/segment_readback.md
# segment_readback

Recovers the 8-bit value (0..255) from the pair of 9-bit seven-segment display buses driven by the board's two-digit display driver. Used for loopback self-test and on-board monitoring of the displayed count. Inputs are synchronised and deglitched, then the segment patterns are validated and decoded. Each newly stable, legal value is published with a one-cycle strobe. Illegal patterns are flagged.

## Interface
- `SYNC_STAGES`, default 2: input synchroniser depth; legal range 0..3, where 0 means inputs are already in the `clk_i` domain.
- `STABLE_CYCLES`, default 4: consecutive identical samples required before decoding; legal range 1..255.
- `clk_i`  in  1  system clock, the only clock.
- `rst_i`  in  1  synchronous, active-high reset.
- `segment_led_1_i`  in  9  tens digit bus. Bits [6:0] are segments a..g. Bit [7] is the dp flag for "count ≥ 200". Bit [8] indicates the source is in reset.
- `segment_led_2_i`  in  9  ones digit bus. Bits [6:0] are segments a..g. Bit [7] is the dp flag for "count ≥ 100". Bit [8] indicates the source is in reset.
- `count_o`  out  8  last decoded legal value.
- `valid_o`  out  1  one-cycle strobe when `count_o` is updated.
- `locked_o`  out  1  high while the inputs are stable and decode to `count_o`.
- `err_o`  out  1  one-cycle strobe when a stable snapshot is illegal.

## Operation
- **Reset:** `rst_i` high at an edge sets the following.
  - Synchroniser flops and the snapshot register load 9'h100 on both buses, i.e. the source-reset bit is set.
  - Stability counter is 0 and state is IDLE.
  - `count_o`, `valid_o`, `locked_o` and `err_o` are all 0.
- **Snapshot:** compare the synchroniser output to the 18-bit snapshot register.
  - On a difference: load the snapshot, set the counter to 1, and clear the err-issued flag.
  - When equal: the counter increments and saturates at `STABLE_CYCLES`.
- **Digit decode**, per bus, bits [6:0]: only the glyphs 0..9 are legal.
  - Glyph values: 3f, 06, 5b, 4f, 66, 6d, 7d, 07, 7f, 6f.
  - Any other pattern, including A..F and 40, is illegal.
- **Hundreds** `h`, from {seg1[7], seg2[7]}: 00 gives 0, 01 gives 1, 11 gives 2, 10 is illegal.
- **Value:** computed in 10 bits as `h*100 + tens*10 + ones`. A result above 255 is illegal; truncate to 8 bits only after this check.
- **FSM** has three states: IDLE, SETTLE, LOCKED.
  - **Any state:** if seg1[8] or seg2[8] is set in the synchroniser output, go to IDLE at the next edge. `count_o` and `locked_o` go to 0; no strobes fire. This rule has priority over every other transition.
  - **IDLE:** when both bit [8] are 0, go to SETTLE.
  - **SETTLE, counter == `STABLE_CYCLES`, legal snapshot:** go to LOCKED. Load `count_o` and raise `locked_o`. Pulse `valid_o` if the value differs from `count_o` or this is the first lock since IDLE.
  - **SETTLE, counter == `STABLE_CYCLES`, illegal snapshot:** pulse `err_o` once, then stay in SETTLE. Do not pulse again until the snapshot changes.
  - **LOCKED:** on any snapshot change, go to SETTLE. `locked_o` drops at that edge; `count_o` holds its value.
- **Glitch that returns to the same value:** re-lock with no `valid_o` pulse.
- **Ordering:** `valid_o` and `err_o` are never high in the same cycle.

## Timing
- An input change is captured at edge 1 and reaches the synchroniser output at edge `SYNC_STAGES`.
  - Edge `SYNC_STAGES`+1: snapshot loaded, counter = 1.
  - Edge `SYNC_STAGES`+`STABLE_CYCLES`+1: `count_o`, `valid_o` and `locked_o` are updated.
- Default latency is 7 cycles.
- `locked_o` falls `SYNC_STAGES`+1 cycles after an input change.
- Source reset (bit [8]) forces IDLE `SYNC_STAGES`+1 cycles after bit [8] rises.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- Package `segment_pkg` holds:
  - the 16-entry glyph constant array, shared with the display driver;
  - bit-index constants: `SEG_DP` = 7, `SEG_RST` = 8;
  - the state enum `seg_rb_state_t` with values IDLE, SETTLE, LOCKED.
- Sub-module `seg_glyph_decode`: combinational, 7-bit pattern in, 4-bit digit plus `illegal` flag out. Instantiate it twice.
- Top-level contents: synchroniser, snapshot register, counter, value arithmetic, FSM and output registers.

## Test plan
- **Single value, defaults:** after reset, hold seg1 = 9'h05b and seg2 = 9'h0cf → `valid_o` pulses 7 cycles later, `count_o` = 123, `locked_o` = 1.
- **Boundary values:** seg1 = seg2 = 9'h0ed → `count_o` = 255. seg1 = 9'h0ed, seg2 = 9'h0fd (256) → `err_o` pulses once, `locked_o` = 0, `count_o` is unchanged.
- **Glitch rejection:** while locked at 123, apply one-cycle changes of seg2 to 9'h0c6 shorter than `STABLE_CYCLES` → `locked_o` drops, then re-locks at 123 with no `valid_o` pulse.
- **Illegal inputs:** glyph 7'h77 on the ones digit, or dp pattern 10 → single `err_o` pulse; no further pulse while held.
- **Source reset:** while locked, set bit [8] on seg1 → after 3 cycles `count_o` = 0 and `locked_o` = 0. Clearing bit [8] with the value 9'h03f/9'h03f held → `valid_o` pulses with `count_o` = 0.
- **Local reset:** assert `rst_i` mid-SETTLE → all outputs are 0 at the next edge. With `SYNC_STAGES` = 0 and `STABLE_CYCLES` = 1, the latency is 2 cycles.
